// File: rtl/spart_pkg.sv
// Shared SPART transmit definitions: FSM states, data width, line levels.
// SPART_TXQ_PARITY_EN adds the PARITY state (even parity bit before STOP).
package spart_pkg;
    localparam int DATA_W       = 8;
    localparam int BAUD_DIV_DEF = 434;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef SPART_TXQ_PARITY_EN
        ST_PARITY = 3'd4,
`endif
        ST_STOP   = 3'd3
    } tx_state_e;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
endpackage

// File: rtl/spart_tx_queue_if.sv
// Pipeline-facing bundle of the SPART transmit queue: byte write strobe,
// occupancy flags and the serial line.
interface spart_tx_queue_if #(
    parameter int AW = 3
);
    logic        send;
    logic [7:0]  tx_data;
    logic        full;
    logic        empty;
    logic [AW:0] count;
    logic        txd;
    logic        busy;

    modport master (
        output send, tx_data,
        input  full, empty, count, txd, busy
    );

    modport slave (
        input  send, tx_data,
        output full, empty, count, txd, busy
    );
endinterface

// File: rtl/spart_tx_fifo.sv
// Byte FIFO for the SPART transmitter; full/empty derive from the registered
// count only, so a same-cycle pop never frees a slot for a push.
module spart_tx_fifo
    import spart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [AW:0]       count_o
);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q, count_d;
    logic              push_ok, pop_ok;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers are AW bits wide, so they wrap mod DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count_q <= DEPTH_C);
            assert (!(pop_i && count_q == '0));
        end
    end
endmodule

// File: rtl/spart_tx_queue.sv
// SPART transmit queue: FIFO plus 8N1 LSB-first serialiser with a registered txd.
// Define SPART_TXQ_PARITY_EN to insert an even-parity bit between data and stop.
module spart_tx_queue
    import spart_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int AW       = 3,
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst,
    spart_tx_queue_if.slave  bus
);
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

    tx_state_e         state_q, state_d;
    logic [15:0]       baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              txd_q, txd_d;
`ifdef SPART_TXQ_PARITY_EN
    logic              par_q, par_d;
`endif

    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_full, fifo_empty, pop;
    logic [AW:0]       fifo_count;
    logic              baud_end;

    spart_tx_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.send),
        .wdata_i (bus.tx_data),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef SPART_TXQ_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    state_d = ST_START;
                    baud_d  = '0;
                    bit_d   = '0;
`ifdef SPART_TXQ_PARITY_EN
                    par_d   = even_parity(fifo_rdata);
`endif
                end
            end
            ST_START: begin
                if (baud_end) begin
                    state_d = ST_DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d  = baud_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef SPART_TXQ_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
`ifdef SPART_TXQ_PARITY_EN
            ST_PARITY: begin
                if (baud_end) begin
                    state_d = ST_STOP;
                    baud_d  = '0;
                end else begin
                    baud_d  = baud_q + 16'd1;
                end
            end
`endif
            ST_STOP: begin
                if (baud_end) begin
                    state_d = ST_IDLE;
                    baud_d  = '0;
                end else begin
                    baud_d  = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
            end
        endcase

        // Line level follows the next state so txd is a plain flop output.
        case (state_d)
            ST_START:  txd_d = LINE_START;
            ST_DATA:   txd_d = shift_d[0];
`ifdef SPART_TXQ_PARITY_EN
            ST_PARITY: txd_d = par_d;
`endif
            ST_STOP:   txd_d = LINE_STOP;
            default:   txd_d = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= LINE_IDLE;
`ifdef SPART_TXQ_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
`ifdef SPART_TXQ_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.full  = fifo_full;
    assign bus.empty = fifo_empty;
    assign bus.count = fifo_count;
    assign bus.txd   = txd_q;
    assign bus.busy  = (state_q != ST_IDLE);
endmodule

// File: tb/tb_spart_tx_queue.sv
// Self-checking bench for spart_tx_queue: per-scenario tasks plus a UART
// receiver that pops expected bytes from a scoreboard as frames arrive.
module tb_spart_tx_queue;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int B     = 4;
`ifdef SPART_TXQ_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    logic [7:0] sb[$];
    int         starts[$];

    spart_tx_queue_if #(.AW(AW)) bus();

    spart_tx_queue #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .BAUD_DIV (B)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Receiver: every bit must hold for B cycles; data compared to the scoreboard.
    int         m_cnt, m_b, m_p;
    logic       m_act = 1'b0;
    logic       m_cur, m_ok;
    logic [7:0] m_data, m_exp;
    logic       m_sb_empty;

    always @(negedge clk) begin
        if (rst) begin
            m_act = 1'b0;
        end else if (!m_act) begin
            if (bus.txd === 1'b0) begin
                m_act  = 1'b1;
                m_cnt  = 1;
                m_cur  = 1'b0;
                m_ok   = 1'b1;
                m_data = '0;
                starts.push_back(cyc);
            end
        end else begin
            m_b = m_cnt / B;
            m_p = m_cnt % B;
            if (m_p == 0) m_cur = bus.txd;
            else if (bus.txd !== m_cur) m_ok = 1'b0;
            if (m_p == B-1) begin
                if (m_b >= 1 && m_b <= 8) m_data[m_b-1] = m_cur;
`ifdef SPART_TXQ_PARITY_EN
                if (m_b == 9 && m_cur !== (^m_data)) m_ok = 1'b0;
`endif
                if (m_b == FB-1) begin
                    if (m_cur !== 1'b1) m_ok = 1'b0;
                    m_sb_empty = (sb.size() == 0);
                    m_exp = m_sb_empty ? 8'hxx : sb.pop_front();
                    checks++;
                    if (!m_ok || m_sb_empty || m_data !== m_exp) begin
                        errors++;
                        $display("FAIL rx_frame: got byte %h (framing_ok=%0d) expected %h (scoreboard_empty=%0d)",
                                 m_data, m_ok, m_exp, m_sb_empty);
                    end
                    m_act = 1'b0;
                end
            end
            m_cnt++;
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(bus.empty === 1'b1 && bus.busy === 1'b0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL %s_idle_timeout: busy=%b empty=%b, required idle within 2000 cycles", name, bus.busy, bus.empty);
        end
    endtask

    // One write into an idle queue, then the whole frame checked cycle by cycle.
    task automatic send_frame(input logic [7:0] d, input string name, output logic par_seen);
        logic [10:0] exp;
        logic        bad;
        exp = '1;
        exp[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp[1+i] = d[i];
`ifdef SPART_TXQ_PARITY_EN
        exp[9] = 1'b0;
        for (int i = 0; i < 8; i++) exp[9] = exp[9] ^ d[i];
`endif
        par_seen = 1'bx;
        @(negedge clk);
        bus.send = 1'b1;
        bus.tx_data = d;
        sb.push_back(d);
        @(negedge clk);
        bus.send = 1'b0;
        checks++;
        if ({bus.txd, bus.busy, bus.count} !== {1'b1, 1'b0, 4'd1}) begin
            errors++;
            $display("FAIL %s_after_write: txd/busy/count=%b/%b/%0d required 1/0/1", name, bus.txd, bus.busy, bus.count);
        end
        for (int b = 0; b < FB; b++) begin
            bad = 1'b0;
            for (int c = 0; c < B; c++) begin
                @(negedge clk);
                if (bus.txd !== exp[b]) bad = 1'b1;
                if (b == 9 && c == 0) par_seen = bus.txd;
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL %s_bit%0d: txd=%b at end, required %b for %0d cycles", name, b, bus.txd, exp[b], B);
            end
        end
        @(negedge clk);
        checks++;
        if ({bus.txd, bus.busy} !== 2'b10) begin
            errors++;
            $display("FAIL %s_frame_end: txd/busy=%b/%b required 1/0 after %0d cycles", name, bus.txd, bus.busy, FB*B);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.send = 1'b0;
        bus.tx_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.txd, bus.empty, bus.full, bus.count, bus.busy} !== {1'b1, 1'b1, 1'b0, 4'd0, 1'b0}) begin
                errors++;
                $display("FAIL reset_idle cyc%0d: txd/empty/full/count/busy=%b/%b/%b/%0d/%b required 1/1/0/0/0",
                         i, bus.txd, bus.empty, bus.full, bus.count, bus.busy);
            end
        end
    endtask

    task automatic test_single_byte();
        logic p;
        send_frame(8'h55, "byte55", p);
        send_frame(8'hC1, "byteC1", p);
        wait_idle("single");
    endtask

    task automatic test_back_to_back();
        int  n;
        int  pre;
        starts.delete();
        @(negedge clk);
        bus.send = 1'b1;
        bus.tx_data = 8'hAA;
        sb.push_back(8'hAA);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            bus.tx_data = 8'(i);
            sb.push_back(8'(i));
        end
        @(negedge clk);
        checks++;
        if ({bus.full, bus.count} !== {1'b1, 4'd8}) begin
            errors++;
            $display("FAIL fill_8: full/count=%b/%0d required 1/8", bus.full, bus.count);
        end
        bus.tx_data = 8'h09;
        sb.push_back(8'h09);
        n = 0;
        pre = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus.count === 4'd8) pre++;
        end while (bus.count !== 4'd7 && n < 200);
        checks++;
        if (n >= 200 || bus.full !== 1'b0 || pre < 30) begin
            errors++;
            $display("FAIL full_pop_refuse: count=%0d full=%b after %0d cycles (held full %0d), required 7/0 with push refused",
                     bus.count, bus.full, n, pre);
        end
        @(negedge clk);
        bus.send = 1'b0;
        checks++;
        if ({bus.full, bus.count} !== {1'b1, 4'd8}) begin
            errors++;
            $display("FAIL full_pop_retry: full/count=%b/%0d required 1/8", bus.full, bus.count);
        end
        wait_idle("b2b");
        @(negedge clk);
        checks++;
        if (sb.size() != 0 || starts.size() != 10) begin
            errors++;
            $display("FAIL b2b_all_sent: leftover=%0d frames=%0d required 0/10", sb.size(), starts.size());
        end
        for (int i = 1; i < starts.size(); i++) begin
            checks++;
            if (starts[i] - starts[i-1] != FB*B + 1) begin
                errors++;
                $display("FAIL b2b_spacing%0d: %0d cycles between starts, required %0d", i, starts[i] - starts[i-1], FB*B + 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        int nstart;
        int lows = 0;
        int busys = 0;
        @(negedge clk);
        bus.send = 1'b1;
        bus.tx_data = 8'hA3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.tx_data = 8'h10 + 8'(i);
        end
        @(negedge clk);
        bus.send = 1'b0;
        repeat (2*B) @(negedge clk);
        checks++;
        if ({bus.busy, bus.count} !== {1'b1, 4'd3}) begin
            errors++;
            $display("FAIL rstmid_pre: busy/count=%b/%0d required 1/3", bus.busy, bus.count);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus.txd, bus.count, bus.busy, bus.empty} !== {1'b1, 4'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_abort: txd/count/busy/empty=%b/%0d/%b/%b required 1/0/0/1",
                     bus.txd, bus.count, bus.busy, bus.empty);
        end
        nstart = starts.size();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.txd !== 1'b1) lows++;
            if (bus.busy !== 1'b0) busys++;
        end
        checks++;
        if (lows != 0 || busys != 0 || starts.size() != nstart) begin
            errors++;
            $display("FAIL rstmid_quiet: txd low %0d cycles, busy %0d cycles, new frames %0d; required none",
                     lows, busys, starts.size() - nstart);
        end
    endtask

`ifdef SPART_TXQ_PARITY_EN
    task automatic test_parity();
        logic p;
        send_frame(8'h07, "par07", p);
        checks++;
        if (p !== 1'b1) begin
            errors++;
            $display("FAIL parity_07: parity bit %b required 1", p);
        end
        send_frame(8'h03, "par03", p);
        checks++;
        if (p !== 1'b0) begin
            errors++;
            $display("FAIL parity_03: parity bit %b required 0", p);
        end
        wait_idle("parity");
    endtask
`endif

    initial begin
        rst = 1'b1;
        bus.send = 1'b0;
        bus.tx_data = '0;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_reset_mid();
`ifdef SPART_TXQ_PARITY_EN
        test_parity();
`endif
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spart_tx_queue.md
Name: spart_tx_queue

Overview:
- Transmit side of the SPART (serial port) path. Consumes the `send` strobe and byte the pipeline issues for an output instruction.
- Buffers the bytes in a FIFO and serialises them onto the UART TX line: 8N1 framing, LSB first.
- Produces `full`, which the pipeline stall controller uses to freeze PC/IF-ID/ID-EX while the queue cannot accept a byte.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of two, at least 2.
- AW, 3, log2(DEPTH); width of the FIFO pointers.
- BAUD_DIV, 434, clk cycles per serial bit (50 MHz / 115200). Legal range 2..65535.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- send  input  1  byte-write request from the pipeline.
- tx_data  input  8  byte to enqueue; sampled when a write is accepted.
- full  output  1  queue holds DEPTH entries; combinational from registered count only.
- empty  output  1  queue holds 0 entries.
- count  output  AW+1  current occupancy, 0..DEPTH.
- txd  output  1  serial line; idles high.
- busy  output  1  a frame is in flight, i.e. the FSM is not IDLE.

Behaviour:
- Reset: count=0, rd/wr pointers=0, FSM=IDLE, txd=1, busy=0, full=0, empty=1, baud counter=0, bit index=0.
- Reset mid-frame aborts the frame immediately: txd=1 on the next cycle, queued bytes are discarded.
- Write accepted iff send & ~full.
  - mem[wr_ptr] <= tx_data, wr_ptr++ (wraps mod DEPTH), count++.
- send & full: no write and no state change. Upstream keeps send/tx_data asserted while stalled; the write retries every cycle.
- full depends only on registered count, never on the same-cycle pop. A push is refused when count==DEPTH even if a pop occurs that cycle. This keeps the `full` → stall path short.
- Pop occurs only when FSM=IDLE & ~empty.
  - Shift register <= mem[rd_ptr], rd_ptr++, count--, FSM -> START.
- Simultaneous accepted push and pop: count unchanged; both pointers advance.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If ~empty, pop and go to START.
  - START: txd=0 for BAUD_DIV cycles, then DATA with bit index=0.
  - DATA: txd=shift[0] for BAUD_DIV cycles each. Shift right after each bit. After bit 7, go to STOP.
  - STOP: txd=1 for BAUD_DIV cycles, then IDLE.
- Baud counter counts 0..BAUD_DIV-1 and is cleared on every state entry. Each bit lasts exactly BAUD_DIV cycles.
- Frame timing: 10*BAUD_DIV cycles per frame.
  - Back-to-back frames add 1 IDLE cycle between frames, so consecutive start bits are 10*BAUD_DIV+1 cycles apart.
- Write-to-first-start-bit latency (empty queue, FSM idle): the write is accepted in cycle N, pop occurs in N+1, txd=0 from N+2.
- txd is driven from a register, glitch-free.
- count never exceeds DEPTH and never underflows; both conditions are assertion-checked.

Optional Feature:
- Macro: SPART_TXQ_PARITY_EN.
- When defined: a PARITY state is inserted between DATA and STOP.
  - txd = even parity (XOR of the 8 data bits) for BAUD_DIV cycles.
  - Frame becomes 11*BAUD_DIV cycles.
- When undefined: 8N1 only; the PARITY state and parity logic do not exist.

Decomposition:
- Shared package `spart_pkg`: FSM state enum (IDLE/START/DATA/STOP/PARITY), DATA_W=8, default BAUD_DIV constant, and the line idle/start/stop level constants.
- One natural sub-module, `spart_tx_fifo`: storage, pointers, count, full/empty, push/pop.
- The top level holds the FSM, baud counter and shift register.

Test Plan:
- Reset then idle 100 cycles -> txd=1, empty=1, full=0, count=0, busy=0 throughout.
- send=1 with tx_data=0x55 for one cycle, BAUD_DIV=4 -> txd sequence 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each bit held 4 cycles, start bit 2 cycles after the write.
- DEPTH=8, 9 consecutive send cycles with data 0x01..0x09 while a frame is in flight -> full=1 after 8 pushes; 0x09 held until a pop frees a slot, then accepted; all 9 bytes transmitted in order.
- Queue full and FSM popping in the same cycle with send=1 -> push refused that cycle (count 8→7), accepted next cycle (count 7→8).
- rst asserted mid-DATA of 0xA3 with 3 bytes queued -> next cycle txd=1, count=0, busy=0; no further frames.
- SPART_TXQ_PARITY_EN defined, byte 0x07 -> parity bit=1, frame length 11*BAUD_DIV; byte 0x03 -> parity bit=0.
